frogg_input_conditioner: RTL and testbench
==========================================

// Module: frogg_input_conditioner
// PURPOSE
//  Conditions the raw board push-buttons feeding the Frogg game core. Directly upstream of
//  the game top: its outputs drive the player move and game-start inputs.
//  Per button: 2-flop sync, counter debounce, rising-edge pulse. Directions add hold-to-repeat.
//  Opposite-direction conflicts are resolved before the core sees them.
// PARAMETERS
//  c_DEBOUNCE_CYCLES  250000    cycles input must differ from stable level before accepted (>=2)
//  c_REPEAT_DELAY     12500000  cycles from first move pulse to first auto-repeat pulse (>=2)
//  c_REPEAT_RATE      5000000   cycles between subsequent auto-repeat pulses (>=2)
//  c_CNT_WIDTH        24        width of debounce/repeat counters; must hold max parameter-1
// PORTS
//  i_Clk           in   1  system pixel clock, all logic on rising edge
//  i_Rst_n         in   1  asynchronous active-low reset
//  i_Switch_Up     in   1  raw button, active-high, asynchronous to i_Clk (same for next four)
//  i_Switch_Dn     in   1  raw button
//  i_Switch_Lt     in   1  raw button
//  i_Switch_Rt     in   1  raw button
//  i_Switch_Start  in   1  raw button
//  i_Enable        in   1  high while game running; gates move pulses only
//  o_Move_Up       out  1  one-cycle move pulse (same for Dn/Lt/Rt)
//  o_Move_Dn       out  1  one-cycle move pulse
//  o_Move_Lt       out  1  one-cycle move pulse
//  o_Move_Rt       out  1  one-cycle move pulse
//  o_Game_Start    out  1  one-cycle pulse on Start press
//  o_Level         out  5  debounced levels {Start,Rt,Lt,Dn,Up}
// BEHAVIOUR
//  Reset: all sync flops, stable levels, counters, outputs = 0; direction FSMs = IDLE. Async assert, sync release.
//  Sync: two flops per input. Debounce on sync output s vs stable level L:
//   s==L -> cnt<=0; s!=L and cnt==c_DEBOUNCE_CYCLES-1 -> L<=s, cnt<=0; else cnt<=cnt+1.
//   Any return to L before terminal count clears cnt (glitch rejected).
//  Latency: input held from edge 0 -> L rises at edge c_DEBOUNCE_CYCLES+2 -> pulse high the
//   cycle after edge c_DEBOUNCE_CYCLES+3. Release debounces identically, produces no pulse.
//  Direction FSM (one per Up/Dn/Lt/Rt), timer tmr:
//   IDLE: L rising -> raw pulse, DELAY, tmr<=0.
//   DELAY: L==0 -> IDLE; tmr==c_REPEAT_DELAY-1 -> raw pulse, REPEAT, tmr<=0; else tmr++.
//   REPEAT: L==0 -> IDLE; tmr==c_REPEAT_RATE-1 -> raw pulse, tmr<=0; else tmr++.
//  Output stage (registered, +0 beyond above latency): o_Move_X = raw_X & i_Enable & ~raw_opp,
//   opp pairs Up/Dn and Lt/Rt: same-cycle opposite raw pulses both dropped. Up+Lt together both pass.
//  i_Enable low does not stop FSMs or timers; pulses masked only (no burst on re-enable).
//  Start: edge detect on L only, no repeat, not gated by i_Enable.
//  o_Level = registered copy of stable levels. Counters never wrap: reset at terminal count.
//  Reset mid-press: all state cleared; button still held after release -> full debounce, new first pulse.
// TESTING (bench params: DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_RATE=8)
//  Up high at edge 0, held 60 cyc, i_Enable=1 -> o_Move_Up pulses cycles 7,27,35,43,51,59; none after release.
//  Dn high 3 cyc then low (bounce) x5 -> o_Move_Dn never asserts, o_Level[1] stays 0.
//  Lt and Rt rise same edge, held 10 cyc -> no o_Move_Lt/Rt pulse; o_Level[3:2]=2'b11.
//  i_Enable=0, Start high 10 cyc -> o_Game_Start single pulse at cycle 7; no move pulses.
//  Up held, i_Enable toggled 0 across cycle 27 -> that repeat dropped, cycle 35 pulse present.
//  Up held, i_Rst_n low cycles 15-16 -> outputs 0 async; next o_Move_Up pulse 7 cycles after release.

Source files
------------

// File: rtl/frogg_input_conditioner.sv
// Push-button front end for the Frogg game core: synchronise, debounce and edge-detect
// each button, add hold-to-repeat on directions, and cancel opposing direction pulses.
module frogg_input_conditioner #(
    parameter int c_DEBOUNCE_CYCLES = 250000,
    parameter int c_REPEAT_DELAY    = 12500000,
    parameter int c_REPEAT_RATE     = 5000000,
    parameter int c_CNT_WIDTH       = 24
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Dn,
    input  logic       i_Switch_Lt,
    input  logic       i_Switch_Rt,
    input  logic       i_Switch_Start,
    input  logic       i_Enable,
    output logic       o_Move_Up,
    output logic       o_Move_Dn,
    output logic       o_Move_Lt,
    output logic       o_Move_Rt,
    output logic       o_Game_Start,
    output logic [4:0] o_Level
);

    localparam logic [c_CNT_WIDTH-1:0] DB_LAST   = c_CNT_WIDTH'(c_DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_WIDTH-1:0] DLY_LAST  = c_CNT_WIDTH'(c_REPEAT_DELAY - 1);
    localparam logic [c_CNT_WIDTH-1:0] RATE_LAST = c_CNT_WIDTH'(c_REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } dir_state_t;

    // Bit order everywhere: {Start, Rt, Lt, Dn, Up}
    logic [4:0]             raw_in;
    logic [4:0]             sync1;
    logic [4:0]             sync2;
    logic [4:0]             level;
    logic [c_CNT_WIDTH-1:0] db_cnt [5];

    dir_state_t             dir_state [4];
    logic [c_CNT_WIDTH-1:0] tmr [4];
    logic [3:0]             raw_pulse;

    assign raw_in = {i_Switch_Start, i_Switch_Rt, i_Switch_Lt, i_Switch_Dn, i_Switch_Up};

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A direction fires on its first accepted press, then on each timer expiry while held.
    always_comb begin
        raw_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            case (dir_state[i])
                ST_IDLE:   raw_pulse[i] = level[i];
                ST_DELAY:  raw_pulse[i] = level[i] && (tmr[i] == DLY_LAST);
                ST_REPEAT: raw_pulse[i] = level[i] && (tmr[i] == RATE_LAST);
                default:   raw_pulse[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < 4; i++) begin
                dir_state[i] <= ST_IDLE;
                tmr[i]       <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (dir_state[i])
                    ST_IDLE: begin
                        if (level[i]) begin
                            dir_state[i] <= ST_DELAY;
                            tmr[i]       <= '0;
                        end
                    end
                    ST_DELAY: begin
                        if (!level[i]) begin
                            dir_state[i] <= ST_IDLE;
                        end else if (tmr[i] == DLY_LAST) begin
                            dir_state[i] <= ST_REPEAT;
                            tmr[i]       <= '0;
                        end else begin
                            tmr[i] <= tmr[i] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (!level[i]) begin
                            dir_state[i] <= ST_IDLE;
                        end else if (tmr[i] == RATE_LAST) begin
                            tmr[i] <= '0;
                        end else begin
                            tmr[i] <= tmr[i] + 1'b1;
                        end
                    end
                    default: dir_state[i] <= ST_IDLE;
                endcase
            end
        end
    end

    // o_Level doubles as the previous-level register for the Start edge detect.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Move_Up    <= 1'b0;
            o_Move_Dn    <= 1'b0;
            o_Move_Lt    <= 1'b0;
            o_Move_Rt    <= 1'b0;
            o_Game_Start <= 1'b0;
            o_Level      <= '0;
        end else begin
            o_Move_Up    <= raw_pulse[0] & i_Enable & ~raw_pulse[1];
            o_Move_Dn    <= raw_pulse[1] & i_Enable & ~raw_pulse[0];
            o_Move_Lt    <= raw_pulse[2] & i_Enable & ~raw_pulse[3];
            o_Move_Rt    <= raw_pulse[3] & i_Enable & ~raw_pulse[2];
            o_Game_Start <= level[4] & ~o_Level[4];
            o_Level      <= level;
        end
    end

endmodule

// File: tb/tb_frogg_input_conditioner.sv
// Directed bench for frogg_input_conditioner with short debounce/repeat timings; output
// pulses are matched against a queue of expected {cycle, pulse mask} entries.
module tb_frogg_input_conditioner;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       up    = 1'b0;
    logic       dn    = 1'b0;
    logic       lt    = 1'b0;
    logic       rt    = 1'b0;
    logic       start = 1'b0;
    logic       en    = 1'b0;
    logic       mv_up, mv_dn, mv_lt, mv_rt, game_start;
    logic [4:0] lvl;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int base;

    // Entry: {cycle[31:0], pulse mask {start, rt, lt, dn, up}}
    logic [36:0] exp_q[$];
    logic [36:0] exp_e;
    logic [36:0] got_e;
    logic [4:0]  pulses;

    frogg_input_conditioner #(
        .c_DEBOUNCE_CYCLES(DB),
        .c_REPEAT_DELAY   (RD),
        .c_REPEAT_RATE    (RR),
        .c_CNT_WIDTH      (8)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Switch_Up   (up),
        .i_Switch_Dn   (dn),
        .i_Switch_Lt   (lt),
        .i_Switch_Rt   (rt),
        .i_Switch_Start(start),
        .i_Enable      (en),
        .o_Move_Up     (mv_up),
        .o_Move_Dn     (mv_dn),
        .o_Move_Lt     (mv_lt),
        .o_Move_Rt     (mv_rt),
        .o_Game_Start  (game_start),
        .o_Level       (lvl)
    );

    // Clock and cycle numbering: cyc is the index of the most recent rising edge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_pulse(input int c, input logic [4:0] m);
        logic [31:0] c32;
        c32 = c;
        exp_q.push_back({c32, m});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_level(input string name, input logic [4:0] req);
        checks++;
        if (lvl !== req) begin
            errors++;
            $display("FAIL %s: o_Level=%b required %b (cycle %0d)", name, lvl, req, cyc);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: compare every observed pulse with the queue front; flag overdue entries.
    always @(negedge clk) begin
        pulses = {game_start, mv_rt, mv_lt, mv_dn, mv_up};
        while (exp_q.size() > 0 && int'(exp_q[0][36:5]) < cyc) begin
            exp_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse: no pulse observed, required mask %b at cycle %0d",
                     exp_e[4:0], exp_e[36:5]);
        end
        if (pulses != 5'b0) begin
            checks++;
            got_e = {cyc[31:0], pulses};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: mask %b at cycle %0d, required none", pulses, cyc);
            end else begin
                exp_e = exp_q.pop_front();
                if (got_e !== exp_e) begin
                    errors++;
                    $display("FAIL pulse: mask %b at cycle %0d, required mask %b at cycle %0d",
                             pulses, cyc, exp_e[4:0], exp_e[36:5]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check_level("reset_level", 5'b00000);
        rst_n = 1'b1;
        en    = 1'b1;
        wait_cyc(cyc + 5);

        // Up held 60 cycles: first pulse, delay, then repeat rate
        base = cyc;
        up   = 1'b1;
        expect_pulse(base + 7,  5'b00001);
        expect_pulse(base + 27, 5'b00001);
        expect_pulse(base + 35, 5'b00001);
        expect_pulse(base + 43, 5'b00001);
        expect_pulse(base + 51, 5'b00001);
        expect_pulse(base + 59, 5'b00001);
        wait_cyc(base + 30);
        check_level("up_held_level", 5'b00001);
        wait_cyc(base + 60);
        up = 1'b0;
        wait_cyc(base + 85);
        check_level("up_released_level", 5'b00000);
        check_drained("up_repeat");

        // Dn bounce: 3 high / 3 low, five times, never accepted
        for (int k = 0; k < 5; k++) begin
            dn = 1'b1;
            wait_cyc(cyc + 3);
            dn = 1'b0;
            wait_cyc(cyc + 3);
            check_level("dn_bounce_level", 5'b00000);
        end
        wait_cyc(cyc + 15);

        // Lt and Rt together: levels accepted, both pulses cancelled
        base = cyc;
        lt   = 1'b1;
        rt   = 1'b1;
        wait_cyc(base + 9);
        check_level("lt_rt_level", 5'b01100);
        wait_cyc(base + 10);
        lt = 1'b0;
        rt = 1'b0;
        wait_cyc(base + 30);
        check_level("lt_rt_released", 5'b00000);
        check_drained("lt_rt_conflict");

        // Start with moves disabled: start still pulses once, Up is masked
        base = cyc;
        en    = 1'b0;
        start = 1'b1;
        up    = 1'b1;
        expect_pulse(base + 7, 5'b10000);
        wait_cyc(base + 9);
        check_level("start_up_level", 5'b10001);
        wait_cyc(base + 10);
        start = 1'b0;
        up    = 1'b0;
        wait_cyc(base + 30);
        en = 1'b1;
        check_drained("start_disabled");

        // Up and Lt together: not opposing, both pass
        base = cyc;
        up   = 1'b1;
        lt   = 1'b1;
        expect_pulse(base + 7, 5'b00101);
        wait_cyc(base + 10);
        up = 1'b0;
        lt = 1'b0;
        wait_cyc(base + 30);
        check_drained("up_lt_diagonal");

        // Enable dropped across the first repeat: that pulse lost, later ones kept
        base = cyc;
        up   = 1'b1;
        expect_pulse(base + 7,  5'b00001);
        expect_pulse(base + 35, 5'b00001);
        expect_pulse(base + 43, 5'b00001);
        wait_cyc(base + 26);
        en = 1'b0;
        wait_cyc(base + 27);
        en = 1'b1;
        wait_cyc(base + 40);
        up = 1'b0;
        wait_cyc(base + 60);
        check_drained("enable_gap");

        // Reset mid-press: async clear, then a full new debounce and first pulse
        base = cyc;
        up   = 1'b1;
        expect_pulse(base + 7, 5'b00001);
        wait_cyc(base + 13);
        check_level("pre_reset_level", 5'b00001);
        wait_cyc(base + 14);
        rst_n = 1'b0;
        #1;
        check_level("async_reset_level", 5'b00000);
        wait_cyc(base + 16);
        rst_n = 1'b1;
        expect_pulse(base + 23, 5'b00001);
        wait_cyc(base + 30);
        check_level("post_reset_level", 5'b00001);
        up = 1'b0;
        wait_cyc(base + 50);
        check_level("post_reset_released", 5'b00000);
        check_drained("reset_mid_press");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
